// File: rtl/writeback_buffer_pkg.sv
// Shared register-file types plus the writeback buffer entry layout.
// Used by the writeback buffer and its bypass selectors.
package writeback_buffer_pkg;

  typedef logic [4:0]  RegAddress;
  typedef logic [31:0] Word;

  typedef struct packed {
    RegAddress addr;
    Word       data;
  } WbEntry;

endpackage

// File: rtl/writeback_bypass_select.sv
// Youngest-match lookup over the writeback FIFO; purely combinational, 0 cycles.
// No flow control: it only observes registered buffer state.
module writeback_bypass_select
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  WbEntry [DEPTH-1:0] entries,
  input  logic   [DEPTH-1:0] valid,
  input  logic   [PTR_W-1:0] head,
  input  RegAddress          lookup_addr,
  output logic               hit,
  output Word                data
);

  logic [PTR_W-1:0] idx;

  // Valid entries are contiguous from head, so walking backwards from the
  // slot just before head visits the youngest valid entry first.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(DEPTH - 1 - k);
      if (!hit && valid[idx] && (lookup_addr != '0) &&
          (entries[idx].addr == lookup_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Buffers writeback requests and drains them to the RF write port on rf_grant; bypass visible 1 cycle after accept.
// Backpressure: in_ready = not full from registered count only; a full buffer never passes a request through.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  RegAddress                  in_addr,
  input  Word                        in_data,
  input  logic                       rf_grant,
  output logic                       rf_write_enable,
  output RegAddress                  rf_addr_write,
  output Word                        rf_in,
  input  RegAddress                  lookup_addr1,
  input  RegAddress                  lookup_addr2,
  output logic                       hit1,
  output logic                       hit2,
  output Word                        hit_data1,
  output Word                        hit_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  WbEntry [DEPTH-1:0] entries_q, entries_d;
  logic   [PTR_W-1:0] head_q, head_d;
  logic   [PTR_W-1:0] tail_q, tail_d;
  logic   [CNT_W-1:0] count_q, count_d;
  logic   [DEPTH-1:0] valid;
  logic   [PTR_W-1:0] offset;
  logic               empty;
  logic               alloc;
  logic               pop;

  assign empty           = (count_q == '0);
  assign in_ready        = (count_q < CNT_W'(DEPTH));
  assign rf_write_enable = !empty && rf_grant;
  assign rf_addr_write   = empty ? '0 : entries_q[head_q].addr;
  assign rf_in           = empty ? '0 : entries_q[head_q].data;
  assign count           = count_q;

  // Writes to r0 complete the handshake but are architecturally no-ops.
  assign alloc = in_valid && in_ready && (in_addr != '0);
  assign pop   = rf_write_enable;

  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - head_q;
      valid[i] = (CNT_W'(offset) < count_q);
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (alloc) begin
      entries_d[tail_q] = '{addr: in_addr, data: in_data};
      tail_d            = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({alloc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  writeback_bypass_select #(.DEPTH(DEPTH)) u_bypass1 (
    .entries     (entries_q),
    .valid       (valid),
    .head        (head_q),
    .lookup_addr (lookup_addr1),
    .hit         (hit1),
    .data        (hit_data1)
  );

  writeback_bypass_select #(.DEPTH(DEPTH)) u_bypass2 (
    .entries     (entries_q),
    .valid       (valid),
    .head        (head_q),
    .lookup_addr (lookup_addr2),
    .hit         (hit2),
    .data        (hit_data2)
  );

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
Write-side initiator for the 2-read/1-write register file. Buffers pending register writes from the pipeline's writeback stage in a small FIFO and drains them into the register file's single write port whenever the port is granted. Provides youngest-entry bypass lookups so that the pipeline's two operand reads see buffered, not-yet-committed values.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  a write request is presented.
in_ready  output  1  buffer can accept a request this cycle.
in_addr  input  RegAddress (5)  destination register.
in_data  input  Word (32)  value to write.
rf_grant  input  1  register file write port is available to this block this cycle.
rf_write_enable  output  1  drives the register file write_enable.
rf_addr_write  output  RegAddress  drives the register file addr_write.
rf_in  output  Word  drives the register file in.
lookup_addr1, lookup_addr2  input  RegAddress  operand addresses, the same as register file addr1/addr2.
hit1, hit2  output  1  the buffer holds a pending write to lookup_addrN.
hit_data1, hit_data2  output  Word  value of the youngest pending write to lookup_addrN.
count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - Pointers and count go to 0; all pending entries are discarded.
  - Outputs while reset is high: rf_write_enable=0, hit1=hit2=0, in_ready=1, count=0.
  - rf_addr_write, rf_in, hit_data1 and hit_data2 read 0.
- Push:
  - Occurs when in_valid && in_ready at posedge.
  - in_ready = (count < DEPTH). It is computed from registered state only, with no combinational path from rf_grant.
  - A request to address 0 completes the handshake but creates no entry.
- Drain:
  - rf_addr_write/rf_in always show the head entry, or 0 when empty.
  - rf_write_enable = (count != 0) && rf_grant.
  - The head pops at the same posedge at which the register file commits it.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full with a grant: the pop happens, but in_ready is still 0 that cycle. There is no pass-through.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is separate, so full and empty are unambiguous.
- Ordering: entries drain strictly in FIFO order. Duplicate addresses are all written, and the last one wins in the register file.
- Bypass (combinational from registered state and lookup_addr):
  - hitN = 1 iff a valid entry has addr == lookup_addrN and lookup_addrN != 0.
  - hit_dataN is the data of the youngest such entry, and 0 on a miss.
  - The head entry being written this cycle still counts as a hit, because the register file shows the old value until the posedge.
  - A request on in_* in the same cycle is NOT visible to the bypass.
- Latency: an accepted write is visible through the bypass in the next cycle. It is committed to the register file no earlier than the cycle after acceptance.

Decomposition:
- Word and RegAddress come from the shared types package.
- Add WbEntry (packed struct: RegAddress addr; Word data) to that package.
- Sub-module writeback_bypass_select is instantiated twice. It takes:
  - the entry array;
  - the per-entry valid vector;
  - the head pointer;
  - one lookup address.
  It returns hit/data using an age-ordered priority scan that starts from the tail.
- The FIFO control stays in writeback_buffer.

Test Plan:
- Reset, then push (r5, 55) with rf_grant=0 -> next cycle count=1, hit1=1/hit_data1=55 for lookup r5, rf_write_enable=0. Raise rf_grant -> one cycle of rf_write_enable=1, rf_addr_write=5, rf_in=55, then count=0 and hit1=0.
- rf_grant=0, push 4 entries (r1..r4 = 10..40) -> count=4, in_ready=0. A 5th request is held and not accepted. Grant one cycle -> r1/10 is written and count=3; in_ready=1 the cycle after.
- Push (r7,1), (r7,2), (r7,3) with no grant -> lookup r7 gives hit_data=3. Grant and drain -> writes appear in order 1,2,3, and after 2 pops hit_data=3 still.
- Push (r0, 99) -> handshake completes, count stays 0, lookup r0 gives hit=0.
- With count=2 and rf_grant=1 continuously, push every cycle for 8 cycles -> count stays at 2, all 8 values are written in order, and pointer wrap leaves no lost or duplicated write.
- Fill 3 entries, assert reset for half a cycle mid-drain -> rf_write_enable drops immediately, count=0, in_ready=1, no further writes after release.
